// File: rtl/fsub_pkg.sv
// Shared definitions for the close-path subtractor round/pack stage.
// Optional feature macro: FSUB_ROUND_RNE_EN (round-to-nearest-even when
// defined, truncation otherwise).
package fsub_pkg;

   localparam int DEF_FRAC_WIDTH     = 32;
   localparam int DEF_EXP_WIDTH      = 8;
   localparam int DEF_OUT_FRAC_WIDTH = 24;

   localparam logic signed [DEF_EXP_WIDTH-1:0] EXP_MAX = {1'b0, {(DEF_EXP_WIDTH-1){1'b1}}};
   localparam logic signed [DEF_EXP_WIDTH-1:0] EXP_MIN = {1'b1, {(DEF_EXP_WIDTH-1){1'b0}}};
   localparam int GUARD_POS = DEF_FRAC_WIDTH - DEF_OUT_FRAC_WIDTH - 1;

   // Unrounded subtractor result as delivered by the close path
   typedef struct packed {
      logic                             sign;
      logic signed [DEF_EXP_WIDTH-1:0]  exp;
      logic [DEF_FRAC_WIDTH-1:0]        frac;
   } fsub_unrnd_t;

endpackage

// File: rtl/fsub_rnd_inc.sv
// Rounding increment decision from guard/sticky/lsb.
// With FSUB_ROUND_RNE_EN defined the decision is round-to-nearest-even;
// otherwise the fraction is truncated and the increment is always 0.
module fsub_rnd_inc (
   input  logic guard,
   input  logic sticky,
   input  logic lsb,
   output logic inc
);

`ifdef FSUB_ROUND_RNE_EN
   assign inc = guard & (sticky | lsb);
`else
   logic unused_rnd_bits;
   assign unused_rnd_bits = ^{guard, sticky, lsb};
   assign inc = 1'b0;
`endif

endmodule

// File: rtl/fsub_round_pack.sv
// Round/pack stage behind the close-path floating subtractor.
// Stage 1 splits the fraction and decides the rounding increment,
// stage 2 applies it, renormalizes on carry, flushes zeros and saturates
// the exponent. Rounding mode is selected by FSUB_ROUND_RNE_EN.
module fsub_round_pack
   import fsub_pkg::*;
#(
   parameter int FRAC_WIDTH     = DEF_FRAC_WIDTH,
   parameter int EXP_WIDTH      = DEF_EXP_WIDTH,
   parameter int OUT_FRAC_WIDTH = DEF_OUT_FRAC_WIDTH
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic                        i_sign,
   input  logic [EXP_WIDTH-1:0]        i_exp,
   input  logic [FRAC_WIDTH-1:0]       i_frac,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic                        o_sign,
   output logic [EXP_WIDTH-1:0]        o_exp,
   output logic [OUT_FRAC_WIDTH-1:0]   o_frac,
   output logic                        o_zero,
   output logic                        o_ovf
);

   localparam int D = FRAC_WIDTH - OUT_FRAC_WIDTH;
   localparam logic [EXP_WIDTH-1:0] E_MAX = {1'b0, {(EXP_WIDTH-1){1'b1}}};
   localparam logic [EXP_WIDTH-1:0] E_MIN = {1'b1, {(EXP_WIDTH-1){1'b0}}};
   localparam logic [EXP_WIDTH-1:0] E_ONE = {{(EXP_WIDTH-1){1'b0}}, 1'b1};

   logic                      v1;
   logic                      v2;
   logic                      s1_adv;
   logic                      s2_adv;

   logic                      s1_sign;
   logic [EXP_WIDTH-1:0]      s1_exp;
   logic [OUT_FRAC_WIDTH-1:0] s1_kept;
   logic                      s1_inc;
   logic                      s1_zero;

   logic                      guard;
   logic                      sticky;
   logic                      lsb;
   logic                      inc;
   logic                      in_zero;

   logic [OUT_FRAC_WIDTH:0]   sum;
   logic                      n_sign;
   logic [EXP_WIDTH-1:0]      n_exp;
   logic [OUT_FRAC_WIDTH-1:0] n_frac;
   logic                      n_zero;
   logic                      n_ovf;

   // Plain two-register pipeline: a stage advances when it is empty or
   // the stage after it advances, so o_ready ripples back from i_ready.
   assign s2_adv  = ~v2 | i_ready;
   assign s1_adv  = ~v1 | s2_adv;
   assign o_ready = s1_adv;
   assign o_valid = v2;

   assign guard   = i_frac[D-1];
   assign sticky  = |i_frac[D-2:0];
   assign lsb     = i_frac[D];
   assign in_zero = (i_frac == '0);

   fsub_rnd_inc u_rnd_inc (
      .guard  (guard),
      .sticky (sticky),
      .lsb    (lsb),
      .inc    (inc)
   );

   // Stage 1: capture sign/exp, the kept fraction bits and the round decision
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         v1      <= 1'b0;
         s1_sign <= 1'b0;
         s1_exp  <= '0;
         s1_kept <= '0;
         s1_inc  <= 1'b0;
         s1_zero <= 1'b0;
      end else if (s1_adv) begin
         v1 <= i_valid;
         if (i_valid) begin
            s1_sign <= i_sign;
            s1_exp  <= i_exp;
            s1_kept <= i_frac[FRAC_WIDTH-1 -: OUT_FRAC_WIDTH];
            s1_inc  <= inc;
            s1_zero <= in_zero;
         end
      end
   end

   // Stage 2 datapath: apply increment, renormalize on carry, flush zero, saturate
   always_comb begin
      sum    = {1'b0, s1_kept} + {{OUT_FRAC_WIDTH{1'b0}}, s1_inc};
      n_sign = s1_sign;
      n_exp  = s1_exp;
      n_frac = sum[OUT_FRAC_WIDTH-1:0];
      n_zero = 1'b0;
      n_ovf  = 1'b0;
      if (s1_zero) begin
         n_sign = 1'b0;
         n_exp  = E_MIN;
         n_frac = '0;
         n_zero = 1'b1;
      end else if (sum[OUT_FRAC_WIDTH]) begin
         if (s1_exp == E_MAX) begin
            n_exp  = E_MAX;
            n_frac = '1;
            n_ovf  = 1'b1;
         end else begin
            n_exp  = s1_exp + E_ONE;
            n_frac = sum[OUT_FRAC_WIDTH:1];
         end
      end
   end

   // Stage 2: output registers, frozen while the consumer stalls
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         v2     <= 1'b0;
         o_sign <= 1'b0;
         o_exp  <= '0;
         o_frac <= '0;
         o_zero <= 1'b0;
         o_ovf  <= 1'b0;
      end else if (s2_adv) begin
         v2 <= v1;
         if (v1) begin
            o_sign <= n_sign;
            o_exp  <= n_exp;
            o_frac <= n_frac;
            o_zero <= n_zero;
            o_ovf  <= n_ovf;
         end
      end
   end

endmodule

// File: tb/tb_fsub_round_pack.sv
// Directed bench for fsub_round_pack (32-bit in, 8-bit exp, 24-bit out).
// Expected values follow the rounding mode chosen by FSUB_ROUND_RNE_EN.
module tb_fsub_round_pack;
   import fsub_pkg::*;

`ifdef FSUB_ROUND_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic        i_sign;
   logic [7:0]  i_exp;
   logic [31:0] i_frac;
   logic        o_valid;
   logic        i_ready;
   logic        o_sign;
   logic [7:0]  o_exp;
   logic [23:0] o_frac;
   logic        o_zero;
   logic        o_ovf;

   int n_vec = 0;
   int n_bad = 0;

   always #5 i_clk = ~i_clk;

   fsub_round_pack dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_sign  (i_sign),
      .i_exp   (i_exp),
      .i_frac  (i_frac),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_sign  (o_sign),
      .o_exp   (o_exp),
      .o_frac  (o_frac),
      .o_zero  (o_zero),
      .o_ovf   (o_ovf)
   );

   function automatic logic [35:0] outVec();
      return {o_valid, o_sign, o_exp, o_frac, o_zero, o_ovf};
   endfunction

   function automatic logic [35:0] mkVec(input logic s, input logic [7:0] e,
                                         input logic [23:0] f, input logic z,
                                         input logic ov);
      return {1'b1, s, e, f, z, ov};
   endfunction

   function automatic logic [35:0] streamExp(input int j);
      return mkVec(j[0], 8'(j + 1), 24'h800000 | 24'(j), 1'b0, 1'b0);
   endfunction

   task automatic checkOutput(input string tag, input logic [35:0] expv);
      logic [35:0] obs;
      obs = outVec();
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic expb);
      n_vec++;
      assert (obs === expb) else begin
         n_bad++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expb);
      end
   endtask

   // Present one input for a single cycle; o_ready must already be high
   task automatic applyStimulus(input string tag, input fsub_unrnd_t in);
      i_sign  = in.sign;
      i_exp   = in.exp;
      i_frac  = in.frac;
      i_valid = 1'b1;
      #1;
      checkBit({tag, "_accept"}, o_ready, 1'b1);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   // Send one input and check it appears exactly two edges after acceptance
   task automatic runVector(input string tag, input fsub_unrnd_t in,
                            input logic [35:0] expv);
      applyStimulus(tag, in);
      checkBit({tag, "_lat"}, o_valid, 1'b0);
      @(posedge i_clk);
      #1;
      checkOutput(tag, expv);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          sent;
      int          recv;
      bit          have_hold;
      logic [35:0] hold_vec;
      logic        exp_rdy;

      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_sign  = 1'b1;
      i_exp   = 8'h33;
      i_frac  = 32'hDEAD_BEEF;
      repeat (2) @(posedge i_clk);
      #1;
      checkOutput("reset", 36'h0);
      checkBit("reset_ready", o_ready, 1'b1);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      runVector("basic", '{1'b1, 8'sd5, 32'h8000_0000},
                mkVec(1'b1, 8'h05, 24'h800000, 1'b0, 1'b0));
      runVector("rnd_up", '{1'b0, 8'sd1, 32'h8000_0180},
                mkVec(1'b0, 8'h01, RNE ? 24'h800002 : 24'h800001, 1'b0, 1'b0));
      runVector("tie_even", '{1'b0, 8'sd1, 32'h8000_0080},
                mkVec(1'b0, 8'h01, 24'h800000, 1'b0, 1'b0));
      runVector("sticky_up", '{1'b1, 8'sd2, 32'h8000_0081},
                mkVec(1'b1, 8'h02, RNE ? 24'h800001 : 24'h800000, 1'b0, 1'b0));
      runVector("carry", '{1'b0, 8'sd3, 32'hFFFF_FFFF},
                RNE ? mkVec(1'b0, 8'h04, 24'h800000, 1'b0, 1'b0)
                    : mkVec(1'b0, 8'h03, 24'hFFFFFF, 1'b0, 1'b0));
      runVector("sat", '{1'b1, 8'sd127, 32'hFFFF_FFFF},
                mkVec(1'b1, 8'h7F, 24'hFFFFFF, 1'b0, RNE));
      runVector("zero", '{1'b1, 8'sd10, 32'h0000_0000},
                mkVec(1'b0, 8'h80, 24'h000000, 1'b1, 1'b0));
      runVector("neg_exp", '{1'b0, -8'sd20, 32'hC000_0000},
                mkVec(1'b0, 8'hEC, 24'hC00000, 1'b0, 1'b0));
      @(posedge i_clk);
      #1;
      checkBit("drain_idle", o_valid, 1'b0);

      // Eight back-to-back inputs with the consumer stalled for three cycles
      sent      = 0;
      recv      = 0;
      have_hold = 1'b0;
      hold_vec  = '0;
      for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
         i_ready = !(cyc >= 4 && cyc < 7);
         i_valid = (sent < 8);
         i_sign  = sent[0];
         i_exp   = 8'(sent + 1);
         i_frac  = 32'h8000_0000 | (32'(sent) << 8);
         #1;
         exp_rdy = ((sent - recv) < 2) || i_ready;
         checkBit("stream_ready", o_ready, exp_rdy);
         if (have_hold) begin
            checkOutput("stream_hold", hold_vec);
            have_hold = 1'b0;
         end
         if (o_valid && i_ready) begin
            checkOutput("stream_out", streamExp(recv));
            recv++;
         end else if (o_valid && !i_ready) begin
            hold_vec  = outVec();
            have_hold = 1'b1;
         end
         if (i_valid && o_ready) sent++;
         @(posedge i_clk);
         #1;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      checkBit("stream_count", (recv == 8) && (sent == 8), 1'b1);

      // Fill both stages, then reset and confirm nothing survives
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      applyStimulus("fill_a", '{1'b1, 8'sd9, 32'h9000_0000});
      applyStimulus("fill_b", '{1'b0, 8'sd7, 32'hB000_0000});
      checkBit("midrst_full", o_ready, 1'b0);
      i_rst_n = 1'b0;
      @(posedge i_clk);
      #1;
      checkOutput("midrst", 36'h0);
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      runVector("post_rst", '{1'b1, -8'sd2, 32'hA000_0040},
                mkVec(1'b1, 8'hFE, 24'hA00000, 1'b0, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
